serial_frame_accumulator: RTL

//   Time-serial counterpart of the parallel adder tree: accepts one WIDTH_IN sample
//   per cycle on a valid/ready stream and sums frames of up to NUM_INPUT samples.

---
 rtl/serial_frame_accumulator_pkg.sv | 24 ++
 rtl/serial_frame_accumulator.sv | 84 ++++++++
 2 files changed

// File: rtl/serial_frame_accumulator_pkg.sv
// Shared arithmetic helpers for the adder family: state encoding and operand
// extension used by both the serial accumulator and the parallel adder tree.
package serial_frame_accumulator_pkg;

    typedef enum logic {ACCUM, HOLD} acc_state_t;

    localparam int unsigned EXT_MAX_W = 64;

    // Extends the low width_in bits of data to the full EXT_MAX_W; callers cast down to their sum width.
    function automatic logic [EXT_MAX_W-1:0] ext_operand(
        input logic [EXT_MAX_W-1:0] data,
        input int unsigned          width_in,
        input logic                 is_signed
    );
        logic [EXT_MAX_W-1:0] mask;
        logic [EXT_MAX_W-1:0] msb_shift;
        logic                 fill;
        mask      = {EXT_MAX_W{1'b1}} << width_in;
        msb_shift = data >> (width_in - 1);
        fill      = is_signed & msb_shift[0];
        return fill ? (data | mask) : (data & ~mask);
    endfunction

endpackage

// File: rtl/serial_frame_accumulator.sv
// Time-serial frame summer: accumulates up to NUM_INPUT samples from a
// valid/ready stream and presents one full-precision sum per frame.
module serial_frame_accumulator
    import serial_frame_accumulator_pkg::*;
#(
    parameter int NUM_INPUT = 16,
    parameter int WIDTH_IN  = 16,
    parameter int IS_SIGNED = 1,
    parameter int WIDTH_OUT = WIDTH_IN + $clog2(NUM_INPUT),
    parameter int CNT_W     = $clog2(NUM_INPUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH_IN-1:0]  s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH_OUT-1:0] m_data,
    output logic [CNT_W-1:0]     m_count,
    output logic                 m_err
);

    if (NUM_INPUT < 1 || WIDTH_IN <= 0 || WIDTH_OUT > EXT_MAX_W) begin : gen_param_check
        $error("serial_frame_accumulator: illegal NUM_INPUT/WIDTH_IN");
    end

    acc_state_t           state;
    logic [WIDTH_OUT-1:0] acc;
    logic [CNT_W-1:0]     cnt;

    logic                 in_fire;
    logic                 out_fire;
    logic                 close;
    logic [WIDTH_OUT-1:0] sample_ext;
    logic [WIDTH_OUT-1:0] sum_next;
    logic [CNT_W-1:0]     cnt_next;

    always_comb begin
        s_ready    = ~rst & ena & ((state == ACCUM) | m_ready);
        in_fire    = s_valid & s_ready;
        out_fire   = ena & m_valid & m_ready;
        sample_ext = WIDTH_OUT'(ext_operand(EXT_MAX_W'(s_data), WIDTH_IN, IS_SIGNED != 0));
        sum_next   = acc + sample_ext;
        cnt_next   = cnt + CNT_W'(1);
        close      = s_last | (cnt_next == CNT_W'(NUM_INPUT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= '0;
            m_err   <= 1'b0;
        end else if (ena) begin
            if (out_fire) begin
                m_valid <= 1'b0;
                state   <= ACCUM;
            end
            // acc/cnt are zero while in HOLD, so a sample taken alongside an out
            // handshake goes through the same path as a fresh frame in ACCUM.
            if (in_fire) begin
                if (close) begin
                    m_data  <= sum_next;
                    m_count <= cnt_next;
                    m_err   <= ~s_last;
                    m_valid <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                    state   <= HOLD;
                end else begin
                    acc <= sum_next;
                    cnt <= cnt_next;
                end
            end
        end
    end

endmodule
